niosii_esercitazione_input_pio: RTL and testbench

Parametrised Avalon-MM slave input port for slider/switch/button banks, replacing the fixed 10-bit read-only input port. It adds:
- a two-flop synchroniser and per-bit debounce,
- per-bit edge capture with write-1-to-clear,
- an interrupt mask and a level irq to the Nios II.

It sits between the board I/O pins and the system interconnect, one instance per input bank.

---
 rtl/niosii_esercitazione_input_pio_if.sv | 19 +
 rtl/niosii_esercitazione_input_pio.sv | 129 ++++++++++++
 tb/tb_niosii_esercitazione_input_pio.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/niosii_esercitazione_input_pio_if.sv
// Avalon-MM slave bus bundle for the input PIO: word-addressed register access plus level irq.
interface niosii_esercitazione_input_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/niosii_esercitazione_input_pio.sv
// Input PIO for switch/button banks: sync, per-bit debounce, edge capture (W1C),
// interrupt mask and registered level irq.
module niosii_esercitazione_input_pio #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 0,
    parameter int CNT_W           = 20
) (
    input  logic                              clk,
    input  logic                              reset,
    niosii_esercitazione_input_pio_if.slave   bus,
    input  logic [WIDTH-1:0]                  in_port
);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] deb_dly_q, deb_dly_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] rise, fall, edge_hit, clr_mask;
    logic             wr_mask, wr_edgecap;
    logic             unused_wdata;

    // Only the low WIDTH bits of writedata carry register content.
    assign unused_wdata = ^bus.writedata;

    assign s1_d      = in_port;
    assign s2_d      = s1_q;
    assign deb_dly_d = deb_q;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_deb
            if (DEBOUNCE_CYCLES == 0) begin : g_bypass
                assign deb_d[gi] = s2_q[gi];
            end else begin : g_cnt
                localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
                logic [CNT_W-1:0] cnt_q, cnt_d;
                logic             bit_d;

                // A glitch back to the accepted level restarts the stability count.
                always_comb begin
                    bit_d = deb_q[gi];
                    cnt_d = cnt_q;
                    if (s2_q[gi] == deb_q[gi]) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        bit_d = s2_q[gi];
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                assign deb_d[gi] = bit_d;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
            end
        end
    endgenerate

    assign rise = deb_q & ~deb_dly_q;
    assign fall = ~deb_q & deb_dly_q;

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_hit = rise;
            1:       edge_hit = fall;
            default: edge_hit = rise | fall;
        endcase
    end

    assign wr_mask    = bus.chipselect & bus.write & (bus.address == 2'd2);
    assign wr_edgecap = bus.chipselect & bus.write & (bus.address == 2'd3);
    assign clr_mask   = wr_edgecap ? bus.writedata[WIDTH-1:0] : '0;

    always_comb begin
        // A new edge in the same cycle as its clear keeps the bit set.
        edgecap_d = (edgecap_q & ~clr_mask) | edge_hit;
        irqmask_d = wr_mask ? bus.writedata[WIDTH-1:0] : irqmask_q;
        irq_d     = |(edgecap_q & irqmask_q);
    end

    always_comb begin
        readdata_d = '0;
        case (bus.address)
            2'd0:    readdata_d[WIDTH-1:0] = deb_q;
            2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            deb_dly_q  <= '0;
            edgecap_q  <= '0;
            irqmask_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            deb_q      <= deb_d;
            deb_dly_q  <= deb_dly_d;
            edgecap_q  <= edgecap_d;
            irqmask_q  <= irqmask_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = irq_q;

endmodule

// File: tb/tb_niosii_esercitazione_input_pio.sv
// Directed bench: four instances (rise/fall/both edge, plus a debounce-bypass copy) share one bus.
module tb_niosii_esercitazione_input_pio;

    logic        clk;
    logic        reset;
    logic [9:0]  in_port;
    logic [1:0]  address;
    logic        cs;
    logic        wr;
    logic [31:0] wdata;

    int n_cmp;
    int n_err;

    niosii_esercitazione_input_pio_if if0 ();
    niosii_esercitazione_input_pio_if if1 ();
    niosii_esercitazione_input_pio_if if2 ();
    niosii_esercitazione_input_pio_if if3 ();

    assign if0.address = address;  assign if0.chipselect = cs;
    assign if0.write   = wr;       assign if0.writedata  = wdata;
    assign if1.address = address;  assign if1.chipselect = cs;
    assign if1.write   = wr;       assign if1.writedata  = wdata;
    assign if2.address = address;  assign if2.chipselect = cs;
    assign if2.write   = wr;       assign if2.writedata  = wdata;
    assign if3.address = address;  assign if3.chipselect = cs;
    assign if3.write   = wr;       assign if3.writedata  = wdata;

    niosii_esercitazione_input_pio #(.WIDTH(10), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .CNT_W(20))
        dut_rise (.clk(clk), .reset(reset), .bus(if0.slave), .in_port(in_port));
    niosii_esercitazione_input_pio #(.WIDTH(10), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .CNT_W(20))
        dut_fall (.clk(clk), .reset(reset), .bus(if1.slave), .in_port(in_port));
    niosii_esercitazione_input_pio #(.WIDTH(10), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .CNT_W(20))
        dut_both (.clk(clk), .reset(reset), .bus(if2.slave), .in_port(in_port));
    niosii_esercitazione_input_pio #(.WIDTH(10), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .CNT_W(20))
        dut_nodb (.clk(clk), .reset(reset), .bus(if3.slave), .in_port(in_port));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a;
        cs      = 1'b1;
        wr      = 1'b1;
        wdata   = d;
        tick();
        $display("wr   addr=%0d data=%h", a, d);
        cs    = 1'b0;
        wr    = 1'b0;
        wdata = '0;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset   = 1'b1;
        in_port = 10'h3FF;
        address = 2'd0;
        cs      = 1'b0;
        wr      = 1'b0;
        wdata   = '0;

        repeat (3) tick();
        chk("rst_data", if0.readdata, 32'h0);
        chk("rst_irq", {31'b0, if0.irq}, 32'h0);

        // Input held high through reset: power-up rising edge after the debounce latency.
        reset = 1'b0;
        repeat (3) tick();
        chk("nodb_data_e3", if3.readdata, 32'h0);
        tick();
        chk("nodb_data_e4", if3.readdata, 32'h3FF);
        repeat (2) tick();
        chk("data_e6", if0.readdata, 32'h0);
        tick();
        chk("data_e7", if0.readdata, 32'h3FF);
        address = 2'd3;
        tick();
        chk("pwrup_ec_rise", if0.readdata, 32'h3FF);
        chk("pwrup_ec_fall", if1.readdata, 32'h0);
        chk("pwrup_ec_both", if2.readdata, 32'h3FF);

        bus_write(2'd3, 32'h3FF);
        tick();
        chk("w1c_all", if2.readdata, 32'h0);

        // Falling edges on every bit.
        in_port = 10'h000;
        repeat (10) tick();
        chk("fall_ec_rise", if0.readdata, 32'h0);
        chk("fall_ec_fall", if1.readdata, 32'h3FF);
        chk("fall_ec_both", if2.readdata, 32'h3FF);
        bus_write(2'd3, 32'h3FF);

        // Three-cycle glitch on bit 0 must be rejected.
        address = 2'd0;
        in_port = 10'h001;
        repeat (3) tick();
        in_port = 10'h000;
        repeat (10) tick();
        chk("glitch_data", if0.readdata, 32'h0);
        address = 2'd3;
        tick();
        chk("glitch_ec", if0.readdata, 32'h0);

        // Stable rising edge on bit 0 with IRQMASK=1.
        bus_write(2'd2, 32'h001);
        address = 2'd0;
        in_port = 10'h001;
        repeat (6) tick();
        chk("b0_data_e6", if0.readdata, 32'h0);
        tick();
        chk("b0_data_e7", if0.readdata, 32'h1);
        chk("irq_e7", {31'b0, if0.irq}, 32'h0);
        tick();
        chk("irq_e8", {31'b0, if0.irq}, 32'h1);

        bus_write(2'd3, 32'h001);
        chk("irq_clr_w", {31'b0, if0.irq}, 32'h1);
        tick();
        chk("irq_clr_w1", {31'b0, if0.irq}, 32'h0);

        // Bit 1 edge is masked off.
        in_port = 10'h003;
        repeat (10) tick();
        chk("irq_b1_masked", {31'b0, if0.irq}, 32'h0);
        address = 2'd3;
        tick();
        chk("ec_b1", if0.readdata, 32'h002);

        // Edge on bit 2 in the same cycle as its W1C write.
        in_port = 10'h007;
        repeat (6) tick();
        bus_write(2'd3, 32'h004);
        tick();
        chk("w1c_race", if0.readdata, 32'h006);

        bus_write(2'd2, 32'hFFFFFFFF);
        address = 2'd2;
        tick();
        chk("mask_rd", if0.readdata, 32'h3FF);
        address = 2'd1;
        tick();
        chk("rsvd_rd", if0.readdata, 32'h0);
        bus_write(2'd0, 32'hFFFFFFFF);
        address = 2'd0;
        tick();
        chk("data_ro", if0.readdata, 32'h007);
        chk("irq_pre_rst", {31'b0, if0.irq}, 32'h1);

        // Reset mid-operation.
        reset = 1'b1;
        tick();
        chk("mid_rst_irq", {31'b0, if0.irq}, 32'h0);
        chk("mid_rst_data", if0.readdata, 32'h0);
        reset = 1'b0;
        address = 2'd2;
        tick();
        chk("mid_rst_mask", if0.readdata, 32'h0);
        address = 2'd3;
        tick();
        chk("mid_rst_ec", if0.readdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
